// File: rtl/gfsk_bit_slicer.sv
// GFSK receive bit slicer: finds the strongest sampling phase over the preamble,
// then slices one bit per symbol at that phase from the discriminator sign.
module gfsk_bit_slicer #(
   parameter int FREQ_BIT_WIDTH    = 5,
   parameter int SAMPLE_PER_SYMBOL = 8,
   parameter int ACQ_SYMBOLS       = 8,
   parameter int ACC_BIT_WIDTH     = 10
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic signed [FREQ_BIT_WIDTH-1:0]     freq_sample,
   input  logic                                 freq_sample_valid,
   input  logic                                 freq_sample_valid_last,
   output logic                                 bit_out,
   output logic                                 bit_out_valid,
   output logic                                 bit_out_valid_last,
   output logic [$clog2(SAMPLE_PER_SYMBOL)-1:0] best_phase,
   output logic                                 acq_done
);

   localparam int PH_W    = $clog2(SAMPLE_PER_SYMBOL);
   localparam int ACQ_LEN = ACQ_SYMBOLS * SAMPLE_PER_SYMBOL;
   localparam int CNT_W   = $clog2(ACQ_LEN + 1);
   localparam int ABS_W   = FREQ_BIT_WIDTH + 1;
   localparam int SUM_W   = ((ACC_BIT_WIDTH > ABS_W) ? ACC_BIT_WIDTH : ABS_W) + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACQ   = 2'd1;
   localparam logic [1:0] ST_TRACK = 2'd2;

   localparam logic [ACC_BIT_WIDTH-1:0] ACC_MAX  = '1;
   localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(ACQ_LEN - 1);

   logic [1:0]               state;
   logic [PH_W-1:0]          ph;
   logic [CNT_W-1:0]         cnt;
   logic [ACC_BIT_WIDTH-1:0] acc      [SAMPLE_PER_SYMBOL];
   logic [ACC_BIT_WIDTH-1:0] acc_upd  [SAMPLE_PER_SYMBOL];
   logic [SUM_W-1:0]         acc_sum  [SAMPLE_PER_SYMBOL];
   logic [ABS_W-1:0]         sample_ext;
   logic [ABS_W-1:0]         sample_abs;
   logic [PH_W-1:0]          peak_idx;
   logic [ACC_BIT_WIDTH-1:0] peak_val;

   // Magnitude is one bit wider so the most negative sample keeps its full size.
   always_comb begin
      sample_ext = {freq_sample[FREQ_BIT_WIDTH-1], freq_sample};
      sample_abs = freq_sample[FREQ_BIT_WIDTH-1] ? (~sample_ext + ABS_W'(1)) : sample_ext;
   end

   // The first sample of a packet starts from cleared accumulators.
   always_comb begin
      for (int i = 0; i < SAMPLE_PER_SYMBOL; i++) begin
         acc_sum[i] = (state == ST_IDLE) ? '0 : SUM_W'(acc[i]);
         if (PH_W'(i) == ph)
            acc_sum[i] = acc_sum[i] + SUM_W'(sample_abs);
         acc_upd[i] = (acc_sum[i] > SUM_W'(ACC_MAX)) ? ACC_MAX : acc_sum[i][ACC_BIT_WIDTH-1:0];
      end
   end

   // Strict compare keeps the lowest index on ties.
   always_comb begin
      peak_idx = '0;
      peak_val = acc_upd[0];
      for (int i = 1; i < SAMPLE_PER_SYMBOL; i++) begin
         if (acc_upd[i] > peak_val) begin
            peak_val = acc_upd[i];
            peak_idx = PH_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= ST_IDLE;
         ph                 <= '0;
         cnt                <= '0;
         bit_out            <= 1'b0;
         bit_out_valid      <= 1'b0;
         bit_out_valid_last <= 1'b0;
         best_phase         <= '0;
         acq_done           <= 1'b0;
         for (int i = 0; i < SAMPLE_PER_SYMBOL; i++)
            acc[i] <= '0;
      end else begin
         bit_out_valid      <= 1'b0;
         bit_out_valid_last <= 1'b0;
         if (freq_sample_valid) begin
            ph <= ph + 1'b1;
            case (state)
               ST_IDLE: begin
                  for (int i = 0; i < SAMPLE_PER_SYMBOL; i++)
                     acc[i] <= acc_upd[i];
                  cnt   <= CNT_W'(1);
                  state <= ST_ACQ;
               end
               ST_ACQ: begin
                  for (int i = 0; i < SAMPLE_PER_SYMBOL; i++)
                     acc[i] <= acc_upd[i];
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST && !freq_sample_valid_last) begin
                     best_phase <= peak_idx;
                     acq_done   <= 1'b1;
                     state      <= ST_TRACK;
                  end
               end
               ST_TRACK: begin
                  if (ph == best_phase) begin
                     bit_out       <= ~freq_sample[FREQ_BIT_WIDTH-1];
                     bit_out_valid <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
            // End of packet overrides any state transition taken above.
            if (freq_sample_valid_last) begin
               state              <= ST_IDLE;
               ph                 <= '0;
               acq_done           <= 1'b0;
               bit_out_valid_last <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_gfsk_bit_slicer.sv
// Bench for gfsk_bit_slicer: a packet-level model checks two instances
// (wide and narrow accumulators) every cycle, plus literal spot checks.
module tb_gfsk_bit_slicer;

   localparam int W       = 5;
   localparam int SPS     = 8;
   localparam int ACQ_SYM = 8;
   localparam int ACQ_LEN = SPS * ACQ_SYM;
   localparam int PH_W    = 3;

   logic                clk;
   logic                rst;
   logic signed [W-1:0] freq_sample;
   logic                freq_sample_valid;
   logic                freq_sample_valid_last;
   logic                bo   [2];
   logic                bv   [2];
   logic                bvl  [2];
   logic [PH_W-1:0]     bp   [2];
   logic                done [2];

   int total = 0;
   int bad   = 0;

   int m_n;
   int m_acc [2][SPS];
   int m_best [2];
   int m_bit [2];
   int m_v [2];
   int m_last;
   int m_done;
   int acc_max [2] = '{1023, 63};

   int bits_seen [$];

   gfsk_bit_slicer #(.FREQ_BIT_WIDTH(W), .SAMPLE_PER_SYMBOL(SPS), .ACQ_SYMBOLS(ACQ_SYM),
                     .ACC_BIT_WIDTH(10)) dut (
      .clk(clk), .rst(rst), .freq_sample(freq_sample),
      .freq_sample_valid(freq_sample_valid), .freq_sample_valid_last(freq_sample_valid_last),
      .bit_out(bo[0]), .bit_out_valid(bv[0]), .bit_out_valid_last(bvl[0]),
      .best_phase(bp[0]), .acq_done(done[0]));

   gfsk_bit_slicer #(.FREQ_BIT_WIDTH(W), .SAMPLE_PER_SYMBOL(SPS), .ACQ_SYMBOLS(ACQ_SYM),
                     .ACC_BIT_WIDTH(6)) dut_sat (
      .clk(clk), .rst(rst), .freq_sample(freq_sample),
      .freq_sample_valid(freq_sample_valid), .freq_sample_valid_last(freq_sample_valid_last),
      .bit_out(bo[1]), .bit_out_valid(bv[1]), .bit_out_valid_last(bvl[1]),
      .best_phase(bp[1]), .acq_done(done[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("[TB] FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
      end
   endtask

   // Packet-level view: sample index within the packet decides phase and mode.
   task automatic modelStep(input bit r, input bit v, input int x, input bit l);
      int ph;
      int b;
      if (r) begin
         m_n = 0; m_last = 0; m_done = 0;
         for (int k = 0; k < 2; k++) begin
            m_best[k] = 0; m_bit[k] = 0; m_v[k] = 0;
            for (int i = 0; i < SPS; i++) m_acc[k][i] = 0;
         end
         return;
      end
      m_v[0] = 0; m_v[1] = 0; m_last = 0;
      if (!v) return;
      ph = m_n % SPS;
      for (int k = 0; k < 2; k++) begin
         if (m_n == 0)
            for (int i = 0; i < SPS; i++) m_acc[k][i] = 0;
         if (m_n < ACQ_LEN) begin
            m_acc[k][ph] = m_acc[k][ph] + ((x < 0) ? -x : x);
            if (m_acc[k][ph] > acc_max[k]) m_acc[k][ph] = acc_max[k];
         end else if (ph == m_best[k]) begin
            m_v[k]   = 1;
            m_bit[k] = (x >= 0) ? 1 : 0;
         end
      end
      if (l) begin
         m_last = 1; m_done = 0; m_n = 0;
      end else begin
         if (m_n == ACQ_LEN - 1) begin
            for (int k = 0; k < 2; k++) begin
               b = 0;
               for (int i = 1; i < SPS; i++)
                  if (m_acc[k][i] > m_acc[k][b]) b = i;
               m_best[k] = b;
            end
            m_done = 1;
         end
         m_n++;
      end
   endtask

   task automatic checkOutput();
      for (int k = 0; k < 2; k++) begin
         cmp($sformatf("bit_out_valid[%0d]", k), int'(bv[k]), m_v[k]);
         cmp($sformatf("bit_out_valid_last[%0d]", k), int'(bvl[k]), m_last);
         cmp($sformatf("bit_out[%0d]", k), int'(bo[k]), m_bit[k]);
         cmp($sformatf("best_phase[%0d]", k), int'(bp[k]), m_best[k]);
         cmp($sformatf("acq_done[%0d]", k), int'(done[k]), m_done);
      end
      if (bv[0] === 1'b1) bits_seen.push_back(int'(bo[0]));
   endtask

   task automatic applyStimulus(input bit r, input bit v, input int x, input bit l);
      rst                    = r;
      freq_sample_valid      = v;
      freq_sample            = x[W-1:0];
      freq_sample_valid_last = l;
      @(posedge clk);
      modelStep(r, v, x, l);
      #1;
      checkOutput();
   endtask

   task automatic sendSample(input int x, input bit l);
      applyStimulus(1'b0, 1'b1, x, l);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 1'b0, int'($urandom_range(0, 31)) - 16, 1'b0);
   endtask

   task automatic acquire(input int nsamp, input int peak, input int pmag, input int bmag,
                          input bit alt);
      int mag;
      for (int n = 0; n < nsamp; n++) begin
         mag = ((n % SPS) == peak) ? pmag : bmag;
         if (alt && ((n / SPS) % 2 == 1)) mag = -mag;
         sendSample(mag, 1'b0);
      end
   endtask

   initial begin
      int trk_vals [4];
      int exp_bits [4];
      trk_vals = '{5, 0, -1, -16};
      exp_bits = '{1, 1, 0, 0};
      rst = 1'b1; freq_sample_valid = 1'b0; freq_sample_valid_last = 1'b0; freq_sample = '0;

      for (int i = 0; i < 2; i++)
         applyStimulus(1'b1, 1'b1, int'($urandom_range(0, 31)) - 16, 1'b0);
      cmp("reset_acq_done", int'(done[0]), 0);
      cmp("reset_best", int'(bp[0]), 0);
      cmp("reset_valid", int'(bv[0]), 0);

      // Peak at phase 3, alternating symbol signs.
      bits_seen.delete();
      acquire(ACQ_LEN - 1, 3, 15, 4, 1'b1);
      cmp("acq_done_before_last", int'(done[0]), 0);
      sendSample(-4, 1'b0);
      cmp("acq_done_after_last", int'(done[0]), 1);
      cmp("acq_best3", int'(bp[0]), 3);
      cmp("acq_best3_sat", int'(bp[1]), 3);
      cmp("acq_no_strobes", bits_seen.size(), 0);

      bits_seen.delete();
      for (int s = 0; s < 4; s++)
         for (int p = 0; p < SPS; p++) begin
            idleCycles(int'($urandom_range(0, 2)));
            sendSample((p == 3) ? trk_vals[s] : 2, 1'b0);
         end
      cmp("track_bit_count", bits_seen.size(), 4);
      for (int i = 0; i < 4 && i < bits_seen.size(); i++)
         cmp($sformatf("track_bit%0d", i), bits_seen[i], exp_bits[i]);

      for (int p = 0; p < 5; p++) sendSample(3, 1'b0);
      sendSample(7, 1'b1);
      cmp("eop_last", int'(bvl[0]), 1);
      cmp("eop_valid", int'(bv[0]), 0);
      cmp("eop_acq_done", int'(done[0]), 0);

      // Back-to-back packet reacquires with a new peak.
      acquire(ACQ_LEN, 6, 15, 4, 1'b0);
      cmp("reacq_best6", int'(bp[0]), 6);
      cmp("reacq_best6_sat", int'(bp[1]), 6);
      sendSample(9, 1'b1);
      cmp("reacq_eop_valid", int'(bv[0]), 0);

      // Last sample of acquisition also ends the packet.
      acquire(ACQ_LEN - 1, 1, 15, 4, 1'b0);
      sendSample(4, 1'b1);
      cmp("coinc_acq_done", int'(done[0]), 0);
      cmp("coinc_best_held", int'(bp[0]), 6);
      cmp("coinc_last", int'(bvl[0]), 1);

      // All -16: every phase ties, narrow instance saturates.
      idleCycles(2);
      acquire(ACQ_LEN, 0, -16, -16, 1'b0);
      cmp("tie_model_acc", m_acc[0][0], 128);
      cmp("sat_model_acc", m_acc[1][7], 63);
      cmp("tie_best0", int'(bp[0]), 0);
      cmp("sat_best0", int'(bp[1]), 0);
      sendSample(4, 1'b1);
      cmp("tie_eop_valid", int'(bv[0]), 1);
      cmp("tie_eop_bit", int'(bo[0]), 1);
      cmp("tie_eop_last", int'(bvl[0]), 1);

      // Abort at sample 20 of acquisition, then a one-sample packet.
      acquire(20, 2, 10, 1, 1'b0);
      sendSample(-5, 1'b1);
      cmp("abort_last", int'(bvl[0]), 1);
      cmp("abort_acq_done", int'(done[0]), 0);
      sendSample(-3, 1'b1);
      cmp("single_last", int'(bvl[0]), 1);
      cmp("single_valid", int'(bv[0]), 0);

      // Reset in the middle of tracking.
      acquire(ACQ_LEN, 2, 12, 1, 1'b0);
      cmp("pre_rst_best2", int'(bp[0]), 2);
      for (int n = 0; n < 2 * SPS; n++) sendSample((n % 2 == 0) ? 6 : -6, 1'b0);
      applyStimulus(1'b1, 1'b1, 5, 1'b0);
      bits_seen.delete();
      for (int n = 0; n < 20; n++) sendSample(-7, 1'b0);
      cmp("post_rst_strobes", bits_seen.size(), 0);
      cmp("post_rst_acq_done", int'(done[0]), 0);
      cmp("post_rst_best", int'(bp[0]), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gfsk_bit_slicer.md
Name: gfsk_bit_slicer

Overview:
Receive-side counterpart of the TX Gaussian pulse-shaping path. It takes the signed, oversampled instantaneous-frequency stream from the RX FM discriminator, recovers symbol timing, and slices one bit per symbol. Timing is recovered from energy accumulated per sampling phase over the preamble. The block sits between the discriminator and the access-address correlator / dewhitening stage.

Parameters:
FREQ_BIT_WIDTH, 5, width of signed discriminator sample W
SAMPLE_PER_SYMBOL, 8, oversampling ratio SPS; must be a power of 2, range 2..16
ACQ_SYMBOLS, 8, number of symbols accumulated for phase acquisition; range 1..16
ACC_BIT_WIDTH, 10, unsigned width of each per-phase energy accumulator

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
freq_sample  in  FREQ_BIT_WIDTH  signed discriminator output
freq_sample_valid  in  1  qualifies freq_sample
freq_sample_valid_last  in  1  marks the final sample of a packet; honoured only when valid=1
bit_out  out  1  sliced bit
bit_out_valid  out  1  one-cycle strobe qualifying bit_out
bit_out_valid_last  out  1  one-cycle end-of-packet strobe
best_phase  out  log2(SPS)  selected sampling phase
acq_done  out  1  high while in TRACK

Behaviour:
- Reset (sync, rst=1 at a clk edge): all outputs 0, state IDLE, phase counter 0, accumulators 0. Reset mid-operation aborts immediately; no pending strobe survives.
- Cycles with valid=0: state, counters and accumulators hold; bit_out_valid=0 and bit_out_valid_last=0. bit_out and best_phase hold their last value.
- Phase counter ph increments on each valid sample and wraps from SPS-1 to 0.
- IDLE:
  - The first valid sample is phase 0 of symbol 0.
  - Clear all accumulators, apply the ACQ update for this sample, then go to ACQ.
- ACQ:
  - For each valid sample, acc[ph] += |freq_sample|.
  - Abs is computed in W+1 bits, so -2^(W-1) maps to 2^(W-1).
  - Accumulators saturate at 2^ACC_BIT_WIDTH-1.
  - No bits are emitted in ACQ.
  - After ACQ_SYMBOLS*SPS samples (the last one at ph=SPS-1), register best_phase = argmax(acc), using the updated acc values. Ties resolve to the lowest index. Set acq_done=1 and go to TRACK.
- TRACK, on a valid sample with ph==best_phase:
  - Next cycle: bit_out = ~freq_sample[W-1], so 0 gives 1. bit_out_valid=1 for one cycle.
  - Latency is exactly 1 clk.
- valid_last with valid=1:
  - In TRACK: next cycle bit_out_valid_last=1. If that sample is at best_phase, bit_out_valid is also 1 with its bit; otherwise bit_out_valid=0.
  - In ACQ or IDLE (a one-sample packet): next cycle bit_out_valid_last=1, bit_out_valid=0.
  - In all cases go to IDLE: acq_done=0, ph=0. best_phase holds until the next acquisition completes.
- A new packet may start on the cycle right after valid_last. That sample is phase 0 of the new acquisition.
- A simultaneous valid_last and acquisition completion on the same sample: valid_last wins. Go to IDLE, pulse bit_out_valid_last, do not set acq_done.
- All arithmetic is unsigned except the sign bit taken for slicing.

Test Plan:
- Reset: drive rst=1 for 2 cycles with valid=1 and random samples -> all outputs 0. Release rst -> the first valid sample is treated as phase 0.
- Acquisition: 64 valid samples with |x|=15 at ph=3 and |x|=4 elsewhere, signs alternating per symbol -> best_phase=3, and acq_done rises 1 clk after sample 63. No bit_out_valid during ACQ.
- Tie and saturation: 64 samples all -16 -> every acc=128, best_phase=0. With ACC_BIT_WIDTH=6 and the same stimulus -> acc saturates at 63 and best_phase=0.
- Tracking with gaps: after locking to phase 3, feed symbols whose ph3 samples are +5, 0, -1, -16, with random valid=0 gaps -> bits 1,1,0,0. Each strobe lands exactly 1 clk after its ph3 sample; there are no strobes in the gaps.
- End of packet: valid_last at ph=5 with best_phase=3 -> bit_out_valid_last=1 and bit_out_valid=0. The next packet reacquires from ph=0 and locks to a new peak at phase 6.
- Abort: valid_last at sample 20 of ACQ -> bit_out_valid_last pulse and acq_done stays 0. Separately, rst asserted mid-TRACK -> no further strobes and state IDLE.
